datapath_multicycle: RTL

//  Parametrised multi-cycle RV32I/RV64I-style datapath: next generation of the single-cycle datapath.

---
 rtl/datapath_multicycle.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/datapath_multicycle.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : datapath_multicycle                                          |
// | Brief   : Multi-cycle IF/ID/EX/MEM/WB datapath with memory handshakes. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module datapath_multicycle #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            imem_ack,
    input  logic [31:0]     inst_in,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] data_in,
    input  logic [3:0]      ALU_Control,
    input  logic [2:0]      ImmSel,
    input  logic [1:0]      MemtoReg,
    input  logic            ALUSrc_B,
    input  logic [1:0]      Jump,
    input  logic            Branch,
    input  logic            BranchN,
    input  logic            RegWrite,
    input  logic            MemRead,
    input  logic            MemWrite,
    output logic            imem_req,
    output logic [XLEN-1:0] pc_out,
    output logic [31:0]     ir_out,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] addr_out,
    output logic [XLEN-1:0] data_out,
    output logic [2:0]      state_out,
    output logic            retire
);
    localparam int c_RIDX = $clog2(NREGS);
    localparam int c_SHW  = $clog2(XLEN);

    localparam logic [2:0] c_ST_IF  = 3'd0;
    localparam logic [2:0] c_ST_ID  = 3'd1;
    localparam logic [2:0] c_ST_EX  = 3'd2;
    localparam logic [2:0] c_ST_MEM = 3'd3;
    localparam logic [2:0] c_ST_WB  = 3'd4;

    logic [2:0]       r_state, w_state_nxt;
    logic [XLEN-1:0]  r_pc, r_a, r_b, r_aluout, r_mdr;
    logic [31:0]      r_ir;
    logic             r_zero;
    logic [XLEN-1:0]  r_regs [NREGS];

    logic [31:0]      w_imm32;
    logic [XLEN-1:0]  w_imm, w_opb, w_alu, w_pc_plus4, w_pc_imm, w_pc_nxt, w_wb;
    logic [c_SHW-1:0] w_shamt;
    logic             w_taken, w_rd_ok, w_reg_we;
    logic [4:0]       w_rd;
    logic [c_RIDX-1:0] w_rd_idx, w_rs1_idx, w_rs2_idx;

    // Immediate formats; every format is sign-extended from IR[31]
    always_comb begin
        w_imm32 = 32'd0;
        case (ImmSel)
            3'b000:  w_imm32 = {{20{r_ir[31]}}, r_ir[31:20]};
            3'b001:  w_imm32 = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
            3'b010:  w_imm32 = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
            3'b011:  w_imm32 = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
            3'b100:  w_imm32 = {r_ir[31:12], 12'd0};
            default: w_imm32 = 32'd0;
        endcase
    end
    assign w_imm   = XLEN'($signed(w_imm32));

    assign w_opb   = ALUSrc_B ? w_imm : r_b;
    assign w_shamt = w_opb[c_SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (ALU_Control)
            4'b0000: w_alu = r_a & w_opb;
            4'b0001: w_alu = r_a | w_opb;
            4'b0010: w_alu = r_a + w_opb;
            4'b0110: w_alu = r_a - w_opb;
            4'b0111: w_alu = XLEN'($signed(r_a) < $signed(w_opb));
            4'b1000: w_alu = XLEN'(r_a < w_opb);
            4'b1100: w_alu = r_a ^ w_opb;
            4'b1101: w_alu = r_a >> w_shamt;
            4'b1001: w_alu = XLEN'($signed(r_a) >>> w_shamt);
            4'b1110: w_alu = r_a << w_shamt;
            default: w_alu = '0;
        endcase
    end

    assign w_pc_plus4 = r_pc + XLEN'(4);
    assign w_pc_imm   = r_pc + w_imm;
    assign w_taken    = (Branch & r_zero) | (BranchN & ~r_zero);

    always_comb begin
        w_pc_nxt = w_taken ? w_pc_imm : w_pc_plus4;
        case (Jump)
            2'b01:   w_pc_nxt = w_pc_imm;
            2'b10:   w_pc_nxt = {r_aluout[XLEN-1:1], 1'b0};
            default: w_pc_nxt = w_taken ? w_pc_imm : w_pc_plus4;
        endcase
    end

    always_comb begin
        w_wb = r_aluout;
        case (MemtoReg)
            2'b00:   w_wb = r_aluout;
            2'b01:   w_wb = r_mdr;
            2'b10:   w_wb = w_pc_plus4;
            default: w_wb = w_imm;
        endcase
    end

    // rd beyond the implemented register count (16-entry file) is dropped
    assign w_rd      = r_ir[11:7];
    assign w_rd_ok   = (w_rd != 5'd0) && ((NREGS == 32) || !w_rd[4]);
    assign w_rd_idx  = w_rd[c_RIDX-1:0];
    assign w_rs1_idx = r_ir[15 +: c_RIDX];
    assign w_rs2_idx = r_ir[20 +: c_RIDX];
    assign w_reg_we  = (r_state == c_ST_WB) && RegWrite && w_rd_ok;

    always_comb begin
        w_state_nxt = c_ST_IF;
        case (r_state)
            c_ST_IF:  w_state_nxt = imem_ack ? c_ST_ID : c_ST_IF;
            c_ST_ID:  w_state_nxt = c_ST_EX;
            c_ST_EX:  w_state_nxt = (MemRead | MemWrite) ? c_ST_MEM : c_ST_WB;
            c_ST_MEM: w_state_nxt = dmem_ack ? c_ST_WB : c_ST_MEM;
            c_ST_WB:  w_state_nxt = c_ST_IF;
            default:  w_state_nxt = c_ST_IF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= c_ST_IF;
            r_pc     <= RESET_PC;
            r_ir     <= 32'd0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            r_mdr    <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_ST_IF: if (imem_ack) r_ir <= inst_in;
                c_ST_ID: begin
                    r_a <= r_regs[w_rs1_idx];
                    r_b <= r_regs[w_rs2_idx];
                end
                c_ST_EX: begin
                    r_aluout <= w_alu;
                    r_zero   <= (w_alu == '0);
                end
                c_ST_MEM: if (dmem_ack && !MemWrite) r_mdr <= data_in;
                c_ST_WB:  r_pc <= w_pc_nxt;
                default:  ;
            endcase
        end
    end

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_regs[gi] <= '0;
            end else if (w_reg_we && (w_rd_idx == c_RIDX'(gi))) begin
                r_regs[gi] <= w_wb;
            end
        end
    end

    // Requests are gated by reset so they drop the moment reset asserts
    assign imem_req  = rst & (r_state == c_ST_IF);
    assign dmem_req  = rst & (r_state == c_ST_MEM);
    assign dmem_we   = dmem_req & MemWrite;
    assign retire    = rst & (r_state == c_ST_WB);
    assign pc_out    = r_pc;
    assign ir_out    = r_ir;
    assign addr_out  = r_aluout;
    assign data_out  = r_b;
    assign state_out = r_state;

endmodule
`default_nettype wire
